// File: rtl/rxacl_pkg.sv
// Shared types and constants for the RX ACL payload buffer scheduler.
package rxacl_pkg;

  localparam int AW_BANK = 7;
  localparam int LENW    = 10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } bank_state_e;

  typedef struct packed {
    logic [LENW-1:0] len;
    logic [1:0]      llid;
  } desc_t;

endpackage

// File: rtl/rxacl_bank_state.sv
// One payload bank: EMPTY/FILL/FULL lifecycle plus the descriptor of the packet it holds.
module rxacl_bank_state
  import rxacl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_fill,
  input  logic        wr_commit,
  input  logic        wr_abort,
  input  logic        rd_release,
  input  desc_t       desc_in,
  output bank_state_e state,
  output desc_t       desc
);

  bank_state_e state_q, state_d;
  desc_t       desc_q, desc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      desc_q  <= '0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
    end
  end

  // Abort beats commit; commit straight from EMPTY is a zero-data packet.
  always_comb begin
    state_d = state_q;
    desc_d  = desc_q;
    case (state_q)
      EMPTY: begin
        if (wr_abort) begin
          state_d = EMPTY;
        end else if (wr_commit) begin
          state_d = FULL;
          desc_d  = desc_in;
        end else if (wr_fill) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (wr_abort) begin
          state_d = EMPTY;
        end else if (wr_commit) begin
          state_d = FULL;
          desc_d  = desc_in;
        end
      end
      FULL: begin
        if (rd_release) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign state = state_q;
  assign desc  = desc_q;

endmodule

// File: rtl/rxacl_bank_sched.sv
// Ping-pong bank scheduler and single-port SRAM arbiter for the RX ACL payload buffer.
// Optional RXACL_DROP_CNT_EN adds a saturating dropped-commit counter (drop_cnt, drop_cnt_clr).
module rxacl_bank_sched #(
  parameter int AW_BANK = 7,
  parameter int LENW    = 10
) (
  input  logic               clk_6M,
  input  logic               rst,
  input  logic               lnctrl_we,
  input  logic [AW_BANK-1:0] lnctrl_addr,
  input  logic [31:0]        lnctrl_din,
  input  logic               lnctrl_commit,
  input  logic               lnctrl_abort,
  input  logic [LENW-1:0]    lnctrl_len,
  input  logic [1:0]         lnctrl_llid,
  output logic               rx_flow,
  input  logic               bsm_cs,
  input  logic [AW_BANK-1:0] bsm_addr,
  input  logic               bsm_read_endp,
  output logic               bsm_gnt,
  output logic               bsm_dvalid,
  output logic               bsm_pkt_valid,
  output logic [LENW-1:0]    bsm_pkt_len,
  output logic [1:0]         bsm_pkt_llid,
  output logic [AW_BANK:0]   sram_a,
  output logic [31:0]        sram_din,
  output logic               sram_we,
  output logic               sram_cs
`ifdef RXACL_DROP_CNT_EN
  ,
  input  logic               drop_cnt_clr,
  output logic [7:0]         drop_cnt
`endif
);

  import rxacl_pkg::*;

  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic        dvalid_q, dvalid_d;
  logic        wr_full, wr_acc, commit_acc, abort_acc, rd_release;
  logic [1:0]  bank_fill, bank_commit, bank_abort, bank_release;
  bank_state_e bank_st [2];
  desc_t       bank_desc [2];
  desc_t       desc_in;

  assign desc_in = '{len: lnctrl_len, llid: lnctrl_llid};

  // A FULL write bank means no free bank: writes and commits are silently dropped.
  always_comb begin
    wr_full       = (bank_st[wr_bank_q] == FULL);
    wr_acc        = lnctrl_we & ~wr_full;
    commit_acc    = lnctrl_commit & ~lnctrl_abort & ~wr_full;
    abort_acc     = lnctrl_abort & ~wr_full;
    bsm_pkt_valid = (bank_st[rd_bank_q] == FULL);
    rd_release    = bsm_read_endp & bsm_pkt_valid;

    bank_fill    = '0;
    bank_commit  = '0;
    bank_abort   = '0;
    bank_release = '0;
    bank_fill[wr_bank_q]    = wr_acc;
    bank_commit[wr_bank_q]  = commit_acc;
    bank_abort[wr_bank_q]   = abort_acc;
    bank_release[rd_bank_q] = rd_release;

    wr_bank_d = wr_bank_q ^ commit_acc;
    rd_bank_d = rd_bank_q ^ rd_release;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    rxacl_bank_state u_bank (
      .clk       (clk_6M),
      .rst       (rst),
      .wr_fill   (bank_fill[b]),
      .wr_commit (bank_commit[b]),
      .wr_abort  (bank_abort[b]),
      .rd_release(bank_release[b]),
      .desc_in   (desc_in),
      .state     (bank_st[b]),
      .desc      (bank_desc[b])
    );
  end

  // Air-side writes always win the single SRAM port.
  always_comb begin
    bsm_gnt  = bsm_cs & ~wr_acc & bsm_pkt_valid;
    dvalid_d = bsm_gnt;
    sram_cs  = 1'b0;
    sram_we  = 1'b0;
    sram_a   = '0;
    sram_din = '0;
    if (wr_acc) begin
      sram_cs  = 1'b1;
      sram_we  = 1'b1;
      sram_a   = {wr_bank_q, lnctrl_addr};
      sram_din = lnctrl_din;
    end else if (bsm_gnt) begin
      sram_cs = 1'b1;
      sram_a  = {rd_bank_q, bsm_addr};
    end
  end

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      dvalid_q  <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      dvalid_q  <= dvalid_d;
    end
  end

  assign bsm_dvalid   = dvalid_q;
  assign bsm_pkt_len  = bsm_pkt_valid ? bank_desc[rd_bank_q].len  : '0;
  assign bsm_pkt_llid = bsm_pkt_valid ? bank_desc[rd_bank_q].llid : '0;
  assign rx_flow      = ~((bank_st[0] == FULL) && (bank_st[1] == FULL));

`ifdef RXACL_DROP_CNT_EN
  logic       drop;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // A clear in the same cycle as a drop keeps that drop.
  always_comb begin
    drop       = lnctrl_commit & ~lnctrl_abort & wr_full;
    drop_cnt_d = drop_cnt_q;
    if (drop_cnt_clr) begin
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rxacl_bank_sched.sv
// Directed self-checking bench for rxacl_bank_sched with a behavioural 256x32 SRAM.
module tb_rxacl_bank_sched;

  logic        clk_6M = 1'b0;
  logic        rst = 1'b1;
  logic        lnctrl_we = 1'b0;
  logic [6:0]  lnctrl_addr = '0;
  logic [31:0] lnctrl_din = '0;
  logic        lnctrl_commit = 1'b0;
  logic        lnctrl_abort = 1'b0;
  logic [9:0]  lnctrl_len = '0;
  logic [1:0]  lnctrl_llid = '0;
  logic        rx_flow;
  logic        bsm_cs = 1'b0;
  logic [6:0]  bsm_addr = '0;
  logic        bsm_read_endp = 1'b0;
  logic        bsm_gnt, bsm_dvalid, bsm_pkt_valid;
  logic [9:0]  bsm_pkt_len;
  logic [1:0]  bsm_pkt_llid;
  logic [7:0]  sram_a;
  logic [31:0] sram_din;
  logic        sram_we, sram_cs;
`ifdef RXACL_DROP_CNT_EN
  logic        drop_cnt_clr = 1'b0;
  logic [7:0]  drop_cnt;
`endif

  logic [31:0] mem [256];
  logic [31:0] sram_dout;
  int checks = 0;
  int errors = 0;

  always #5 clk_6M = ~clk_6M;

  always @(posedge clk_6M) begin
    if (sram_cs) begin
      if (sram_we) mem[sram_a] <= sram_din;
      else sram_dout <= mem[sram_a];
    end
  end

  rxacl_bank_sched dut (
    .clk_6M(clk_6M), .rst(rst),
    .lnctrl_we(lnctrl_we), .lnctrl_addr(lnctrl_addr), .lnctrl_din(lnctrl_din),
    .lnctrl_commit(lnctrl_commit), .lnctrl_abort(lnctrl_abort),
    .lnctrl_len(lnctrl_len), .lnctrl_llid(lnctrl_llid), .rx_flow(rx_flow),
    .bsm_cs(bsm_cs), .bsm_addr(bsm_addr), .bsm_read_endp(bsm_read_endp),
    .bsm_gnt(bsm_gnt), .bsm_dvalid(bsm_dvalid), .bsm_pkt_valid(bsm_pkt_valid),
    .bsm_pkt_len(bsm_pkt_len), .bsm_pkt_llid(bsm_pkt_llid),
    .sram_a(sram_a), .sram_din(sram_din), .sram_we(sram_we), .sram_cs(sram_cs)
`ifdef RXACL_DROP_CNT_EN
    , .drop_cnt_clr(drop_cnt_clr), .drop_cnt(drop_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk_6M);
    #1;
  endtask

  task automatic idle;
    lnctrl_we = 1'b0; lnctrl_commit = 1'b0; lnctrl_abort = 1'b0;
    bsm_cs = 1'b0; bsm_read_endp = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle();
    tick(); tick();
    rst = 1'b0;
    #1;
    checks += 8;
    if (rx_flow !== 1'b1) begin errors++; $display("[TB] FAIL reset_rx_flow got %b expected 1", rx_flow); end
    if (bsm_pkt_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pkt_valid got %b expected 0", bsm_pkt_valid); end
    if (bsm_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt got %b expected 0", bsm_gnt); end
    if (bsm_dvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dvalid got %b expected 0", bsm_dvalid); end
    if (bsm_pkt_len !== 10'd0) begin errors++; $display("[TB] FAIL reset_len got %0d expected 0", bsm_pkt_len); end
    if (bsm_pkt_llid !== 2'd0) begin errors++; $display("[TB] FAIL reset_llid got %0d expected 0", bsm_pkt_llid); end
    if (sram_cs !== 1'b0) begin errors++; $display("[TB] FAIL reset_sram_cs got %b expected 0", sram_cs); end
    if (sram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_sram_we got %b expected 0", sram_we); end
  endtask

  task automatic test_abort;
    for (int i = 0; i < 3; i++) begin
      lnctrl_we = 1'b1; lnctrl_addr = 7'(i); lnctrl_din = 32'h5500_0000 + i;
      #1;
      checks++;
      if (sram_a !== 8'(i)) begin errors++; $display("[TB] FAIL abort_wr_addr got %h expected %h", sram_a, 8'(i)); end
      tick();
    end
    lnctrl_we = 1'b0; lnctrl_abort = 1'b1;
    tick();
    lnctrl_abort = 1'b0;
    #1;
    checks += 2;
    if (bsm_pkt_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_pkt_valid got %b expected 0", bsm_pkt_valid); end
    if (rx_flow !== 1'b1) begin errors++; $display("[TB] FAIL abort_rx_flow got %b expected 1", rx_flow); end
    lnctrl_we = 1'b1; lnctrl_addr = 7'd9; lnctrl_din = 32'h1234_5678;
    #1;
    checks += 2;
    if (sram_a !== 8'h09) begin errors++; $display("[TB] FAIL abort_same_bank got %h expected 09", sram_a); end
    if (sram_we !== 1'b1) begin errors++; $display("[TB] FAIL abort_next_we got %b expected 1", sram_we); end
    tick();
    lnctrl_we = 1'b0; lnctrl_abort = 1'b1;
    tick();
    lnctrl_abort = 1'b0;
  endtask

  task automatic test_write_commit_read;
    for (int i = 0; i < 4; i++) begin
      lnctrl_we = 1'b1; lnctrl_addr = 7'(i); lnctrl_din = 32'hA0A0_0000 + i;
      #1;
      checks += 2;
      if (sram_a !== 8'(i)) begin errors++; $display("[TB] FAIL wr_addr got %h expected %h", sram_a, 8'(i)); end
      if (sram_din !== 32'hA0A0_0000 + i) begin errors++; $display("[TB] FAIL wr_din got %h expected %h", sram_din, 32'hA0A0_0000 + i); end
      tick();
    end
    lnctrl_we = 1'b0; lnctrl_commit = 1'b1; lnctrl_len = 10'd13; lnctrl_llid = 2'd2;
    #1;
    checks++;
    if (bsm_pkt_valid !== 1'b0) begin errors++; $display("[TB] FAIL commit_early_valid got %b expected 0", bsm_pkt_valid); end
    tick();
    lnctrl_commit = 1'b0;
    #1;
    checks += 4;
    if (bsm_pkt_valid !== 1'b1) begin errors++; $display("[TB] FAIL commit_valid got %b expected 1", bsm_pkt_valid); end
    if (bsm_pkt_len !== 10'd13) begin errors++; $display("[TB] FAIL commit_len got %0d expected 13", bsm_pkt_len); end
    if (bsm_pkt_llid !== 2'd2) begin errors++; $display("[TB] FAIL commit_llid got %0d expected 2", bsm_pkt_llid); end
    if (rx_flow !== 1'b1) begin errors++; $display("[TB] FAIL commit_rx_flow got %b expected 1", rx_flow); end
    for (int i = 0; i < 4; i++) begin
      bsm_cs = 1'b1; bsm_addr = 7'(i);
      #1;
      checks += 3;
      if (bsm_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rd_gnt got %b expected 1", bsm_gnt); end
      if (sram_a !== 8'(i)) begin errors++; $display("[TB] FAIL rd_addr got %h expected %h", sram_a, 8'(i)); end
      if (sram_we !== 1'b0) begin errors++; $display("[TB] FAIL rd_we got %b expected 0", sram_we); end
      tick();
      bsm_cs = 1'b0;
      #1;
      checks += 2;
      if (bsm_dvalid !== 1'b1) begin errors++; $display("[TB] FAIL rd_dvalid got %b expected 1", bsm_dvalid); end
      if (sram_dout !== 32'hA0A0_0000 + i) begin errors++; $display("[TB] FAIL rd_data got %h expected %h", sram_dout, 32'hA0A0_0000 + i); end
    end
    bsm_read_endp = 1'b1;
    tick();
    bsm_read_endp = 1'b0;
    #1;
    checks++;
    if (bsm_pkt_valid !== 1'b0) begin errors++; $display("[TB] FAIL endp_valid got %b expected 0", bsm_pkt_valid); end
  endtask

  task automatic test_flow_stop;
    lnctrl_we = 1'b1; lnctrl_addr = 7'd0; lnctrl_din = 32'hB1B1_B1B1;
    tick();
    lnctrl_we = 1'b0; lnctrl_commit = 1'b1; lnctrl_len = 10'd4; lnctrl_llid = 2'd1;
    tick();
    lnctrl_commit = 1'b0;
    lnctrl_we = 1'b1; lnctrl_addr = 7'd0; lnctrl_din = 32'hB0B0_B0B0;
    tick();
    lnctrl_we = 1'b0; lnctrl_commit = 1'b1; lnctrl_len = 10'd8; lnctrl_llid = 2'd3;
    tick();
    lnctrl_commit = 1'b0;
    #1;
    checks += 2;
    if (rx_flow !== 1'b0) begin errors++; $display("[TB] FAIL full_rx_flow got %b expected 0", rx_flow); end
    if (bsm_pkt_len !== 10'd4) begin errors++; $display("[TB] FAIL full_len got %0d expected 4", bsm_pkt_len); end
    lnctrl_we = 1'b1; lnctrl_addr = 7'd0; lnctrl_din = 32'hDEAD_BEEF;
    lnctrl_commit = 1'b1; lnctrl_len = 10'd16;
    #1;
    checks += 2;
    if (sram_cs !== 1'b0) begin errors++; $display("[TB] FAIL drop_sram_cs got %b expected 0", sram_cs); end
    if (sram_we !== 1'b0) begin errors++; $display("[TB] FAIL drop_sram_we got %b expected 0", sram_we); end
    tick();
    lnctrl_we = 1'b0; lnctrl_commit = 1'b0;
    #1;
    checks++;
    if (rx_flow !== 1'b0) begin errors++; $display("[TB] FAIL drop_rx_flow got %b expected 0", rx_flow); end
`ifdef RXACL_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL drop_cnt got %0d expected 1", drop_cnt); end
`endif
    bsm_cs = 1'b1; bsm_addr = 7'd0;
    #1;
    checks++;
    if (sram_a !== 8'h80) begin errors++; $display("[TB] FAIL drop_rd_addr got %h expected 80", sram_a); end
    tick();
    bsm_cs = 1'b0;
    #1;
    checks++;
    if (sram_dout !== 32'hB1B1_B1B1) begin errors++; $display("[TB] FAIL drop_unchanged got %h expected b1b1b1b1", sram_dout); end
    bsm_read_endp = 1'b1;
    tick();
    bsm_read_endp = 1'b0;
    #1;
    checks += 4;
    if (rx_flow !== 1'b1) begin errors++; $display("[TB] FAIL release_rx_flow got %b expected 1", rx_flow); end
    if (bsm_pkt_valid !== 1'b1) begin errors++; $display("[TB] FAIL next_valid got %b expected 1", bsm_pkt_valid); end
    if (bsm_pkt_len !== 10'd8) begin errors++; $display("[TB] FAIL next_len got %0d expected 8", bsm_pkt_len); end
    if (bsm_pkt_llid !== 2'd3) begin errors++; $display("[TB] FAIL next_llid got %0d expected 3", bsm_pkt_llid); end
    bsm_cs = 1'b1; bsm_addr = 7'd0;
    tick();
    bsm_cs = 1'b0;
    #1;
    checks++;
    if (sram_dout !== 32'hB0B0_B0B0) begin errors++; $display("[TB] FAIL next_data got %h expected b0b0b0b0", sram_dout); end
    bsm_read_endp = 1'b1;
    tick();
    bsm_read_endp = 1'b0;
  endtask

  task automatic test_back_to_back;
    lnctrl_we = 1'b1; lnctrl_addr = 7'd0; lnctrl_din = 32'hC1C1_C1C1;
    tick();
    lnctrl_we = 1'b0; lnctrl_commit = 1'b1; lnctrl_len = 10'd4; lnctrl_llid = 2'd0;
    tick();
    lnctrl_commit = 1'b0;
    bsm_cs = 1'b1; bsm_addr = 7'd0;
    lnctrl_we = 1'b1; lnctrl_addr = 7'd3; lnctrl_din = 32'hC0C0_C0C0;
    #1;
    checks += 4;
    if (bsm_gnt !== 1'b0) begin errors++; $display("[TB] FAIL coll_gnt got %b expected 0", bsm_gnt); end
    if (sram_we !== 1'b1) begin errors++; $display("[TB] FAIL coll_we got %b expected 1", sram_we); end
    if (sram_a !== 8'h03) begin errors++; $display("[TB] FAIL coll_addr got %h expected 03", sram_a); end
    if (sram_din !== 32'hC0C0_C0C0) begin errors++; $display("[TB] FAIL coll_din got %h expected c0c0c0c0", sram_din); end
    tick();
    lnctrl_we = 1'b0;
    #1;
    checks += 3;
    if (bsm_gnt !== 1'b1) begin errors++; $display("[TB] FAIL retry_gnt got %b expected 1", bsm_gnt); end
    if (sram_a !== 8'h80) begin errors++; $display("[TB] FAIL retry_addr got %h expected 80", sram_a); end
    if (bsm_dvalid !== 1'b0) begin errors++; $display("[TB] FAIL denied_dvalid got %b expected 0", bsm_dvalid); end
    tick();
    bsm_cs = 1'b0;
    #1;
    checks += 2;
    if (bsm_dvalid !== 1'b1) begin errors++; $display("[TB] FAIL retry_dvalid got %b expected 1", bsm_dvalid); end
    if (sram_dout !== 32'hC1C1_C1C1) begin errors++; $display("[TB] FAIL retry_data got %h expected c1c1c1c1", sram_dout); end
  endtask

  task automatic test_commit_release;
    lnctrl_commit = 1'b1; lnctrl_len = 10'd20; lnctrl_llid = 2'd1;
    bsm_read_endp = 1'b1;
    tick();
    lnctrl_commit = 1'b0; bsm_read_endp = 1'b0;
    #1;
    checks += 4;
    if (bsm_pkt_valid !== 1'b1) begin errors++; $display("[TB] FAIL cr_valid got %b expected 1", bsm_pkt_valid); end
    if (bsm_pkt_len !== 10'd20) begin errors++; $display("[TB] FAIL cr_len got %0d expected 20", bsm_pkt_len); end
    if (bsm_pkt_llid !== 2'd1) begin errors++; $display("[TB] FAIL cr_llid got %0d expected 1", bsm_pkt_llid); end
    if (rx_flow !== 1'b1) begin errors++; $display("[TB] FAIL cr_rx_flow got %b expected 1", rx_flow); end
    bsm_cs = 1'b1; bsm_addr = 7'd3;
    #1;
    checks++;
    if (sram_a !== 8'h03) begin errors++; $display("[TB] FAIL cr_rd_addr got %h expected 03", sram_a); end
    tick();
    bsm_cs = 1'b0;
    #1;
    checks++;
    if (sram_dout !== 32'hC0C0_C0C0) begin errors++; $display("[TB] FAIL cr_data got %h expected c0c0c0c0", sram_dout); end
    lnctrl_commit = 1'b1; lnctrl_len = 10'd5; lnctrl_llid = 2'd2;
    tick();
    lnctrl_commit = 1'b0;
    #1;
    checks++;
    if (rx_flow !== 1'b0) begin errors++; $display("[TB] FAIL cr_count2_rx_flow got %b expected 0", rx_flow); end
  endtask

  task automatic test_reset_midpacket;
    bsm_read_endp = 1'b1;
    tick();
    bsm_read_endp = 1'b0;
    #1;
    checks += 2;
    if (bsm_pkt_len !== 10'd5) begin errors++; $display("[TB] FAIL zero_data_len got %0d expected 5", bsm_pkt_len); end
    if (bsm_pkt_llid !== 2'd2) begin errors++; $display("[TB] FAIL zero_data_llid got %0d expected 2", bsm_pkt_llid); end
    for (int i = 0; i < 2; i++) begin
      lnctrl_we = 1'b1; lnctrl_addr = 7'(i); lnctrl_din = 32'hEE00_0000 + i;
      tick();
    end
    lnctrl_we = 1'b0;
    bsm_cs = 1'b1; bsm_addr = 7'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks += 7;
    if (bsm_pkt_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid got %b expected 0", bsm_pkt_valid); end
    if (bsm_pkt_len !== 10'd0) begin errors++; $display("[TB] FAIL mid_rst_len got %0d expected 0", bsm_pkt_len); end
    if (bsm_pkt_llid !== 2'd0) begin errors++; $display("[TB] FAIL mid_rst_llid got %0d expected 0", bsm_pkt_llid); end
    if (rx_flow !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_rx_flow got %b expected 1", rx_flow); end
    if (bsm_gnt !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_gnt got %b expected 0", bsm_gnt); end
    if (sram_cs !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_sram_cs got %b expected 0", sram_cs); end
    if (bsm_dvalid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_dvalid got %b expected 0", bsm_dvalid); end
    bsm_cs = 1'b0;
    lnctrl_we = 1'b1; lnctrl_addr = 7'd1; lnctrl_din = 32'h0F0F_0F0F;
    #1;
    checks++;
    if (sram_a !== 8'h01) begin errors++; $display("[TB] FAIL mid_rst_wr_bank got %h expected 01", sram_a); end
    tick();
    lnctrl_we = 1'b0; lnctrl_commit = 1'b1; lnctrl_len = 10'd2; lnctrl_llid = 2'd1;
    tick();
    lnctrl_commit = 1'b0;
    #1;
    checks += 2;
    if (bsm_pkt_valid !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_valid got %b expected 1", bsm_pkt_valid); end
    if (bsm_pkt_len !== 10'd2) begin errors++; $display("[TB] FAIL post_rst_len got %0d expected 2", bsm_pkt_len); end
  endtask

  initial begin
    test_reset();
    test_abort();
    test_write_commit_read();
    test_flow_stop();
    test_back_to_back();
    test_commit_release();
    test_reset_midpacket();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rxacl_bank_sched.md
# rxacl_bank_sched

Scheduler and arbiter for the RX ACL payload buffer: one 256x32 single-port SRAM split into two 128-word banks used ping-pong. The link controller writes received payloads into the free bank. The baseband state machine reads committed packets out of the other bank. The block owns bank state, single-port arbitration, packet descriptors and the RX FLOW bit reported back to the link controller.

## Interface
Parameters:
- AW_BANK, 7, word address width inside one bank (bank = 2^AW_BANK words)
- LENW, 10, packet length field width in bytes

Ports:
- clk_6M  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- lnctrl_we  in  1  payload word write strobe
- lnctrl_addr  in  7  word offset within current write bank
- lnctrl_din  in  32  payload word
- lnctrl_commit  in  1  packet good; latch descriptor and close bank
- lnctrl_abort  in  1  packet bad (CRC/HEC); discard bank contents
- lnctrl_len  in  10  payload length in bytes, sampled on commit
- lnctrl_llid  in  2  LLID, sampled on commit
- rx_flow  out  1  1 = a free bank exists (FLOW=GO); 0 = STOP
- bsm_cs  in  1  read request for word bsm_addr
- bsm_addr  in  7  word offset within current read bank
- bsm_read_endp  in  1  reader finished; release read bank
- bsm_gnt  out  1  bsm_cs accepted this cycle
- bsm_dvalid  out  1  sram_dout valid for the read granted last cycle
- bsm_pkt_valid  out  1  a committed packet is presented
- bsm_pkt_len  out  10  its length
- bsm_pkt_llid  out  2  its LLID
- sram_a  out  8  {bank, offset}
- sram_din  out  32  write data
- sram_we  out  1  write enable
- sram_cs  out  1  chip select

## Operation
- Per-bank state: EMPTY, FILL, FULL. Pointers: wr_bank, rd_bank, 1 bit each.
- Write: the first lnctrl_we while wr_bank is EMPTY moves it to FILL.
  - lnctrl_commit moves FILL to FULL, stores len/llid and toggles wr_bank.
  - lnctrl_abort moves FILL to EMPTY. wr_bank is unchanged.
  - Commit with no preceding write commits a zero-data packet; the length is still reported.
- Commit or we while wr_bank is FULL (no free bank): the packet is dropped, nothing is written, and state is unchanged.
- Read: bsm_pkt_valid = (rd_bank state == FULL).
  - bsm_read_endp while valid moves rd_bank to EMPTY and toggles rd_bank.
  - bsm_read_endp while not valid is ignored.
- SRAM arbitration: a write has absolute priority because air timing is fixed.
  - bsm_gnt = bsm_cs & ~(write accepted this cycle) & bsm_pkt_valid.
  - A denied reader holds bsm_cs/bsm_addr until granted.
- Mux: a write drives sram_a={wr_bank,lnctrl_addr}, sram_we=1, sram_cs=1. A granted read drives sram_a={rd_bank,bsm_addr}, we=0, cs=1. Otherwise cs=0, we=0, din=0.
- rx_flow = 0 when both banks are FULL (the bank counter is 2), else 1.
- Simultaneous commit and read_endp: both take effect in the same cycle. The counter is unchanged.
- Simultaneous commit and abort: abort wins.

## Timing
- Reset values:
  - Banks EMPTY, wr_bank=rd_bank=0, rx_flow=1.
  - bsm_pkt_valid=0, bsm_gnt=0, bsm_dvalid=0, len/llid=0.
  - sram_cs=sram_we=0.
- SRAM controls are combinational from inputs and current state (zero latency). Read data arrives 1 cycle after the grant; bsm_dvalid is a registered copy of bsm_gnt.
- Commit at cycle N: bsm_pkt_valid=1 at N+1 if that bank is rd_bank. rx_flow updates at N+1.
- bsm_read_endp at N: the next FULL bank (if any) is presented at N+1, with no idle cycle.
- A reset asserted mid-packet discards all banks. No partial packet survives.

## Configuration
- RXACL_DROP_CNT_EN defined: adds output drop_cnt [7:0].
  - Increments once per commit dropped for lack of a bank.
  - Saturates at 255 and clears on rst.
  - Clear-on-read input drop_cnt_clr, 1 bit.
- Undefined: the port and counter are absent. Drop behaviour is identical.

## Structure
- Shared package rxacl_pkg holds:
  - bank state enum {EMPTY, FILL, FULL}
  - AW_BANK and LENW constants
  - descriptor struct {len, llid}
- One sub-module, rxacl_bank_state: per-bank FSM plus descriptor register, instantiated twice. The top holds the pointers, arbitration and mux.

## Test plan
- Write 4 words to bank 0, commit len=13 llid=2 -> next cycle bsm_pkt_valid=1, len=13, llid=2. Reads at offsets 0..3 return the written data with dvalid one cycle later.
- Commit two packets with no reads -> rx_flow=0. A third commit is dropped (drop_cnt=1 with RXACL_DROP_CNT_EN) and the bank contents are unchanged. bsm_read_endp -> rx_flow=1 next cycle.
- Write 3 words, then abort -> no bsm_pkt_valid. The next packet lands in the same bank (sram_a[7] = 0).
- bsm_cs held while lnctrl_we is asserted in the same cycle -> bsm_gnt=0 and the SRAM write occurs. The next cycle gives bsm_gnt=1 and dvalid follows.
- Commit on bank 1 in the same cycle as bsm_read_endp on bank 0 -> next cycle rd_bank=1, valid=1, and the counter stays at 1.
- rst asserted after 2 words of a packet and with one FULL bank -> all outputs at reset values next cycle, rx_flow=1.
